pri_decoder_dispatch: RTL and testbench
=======================================

PRI_DECODER_DISPATCH -- requirements
Module: pri_decoder_dispatch

Interface
REQ-001 Parameter: TIMEOUT_CYC, default 8, cycles without out_ack before forced completion (legal 1..255).
REQ-002 Port: clk  input  1  single clock, all state on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: in_valid  input  1  upstream offers an encoded index.
REQ-005 Port: in_idx  input  2  encoded priority index (0..3).
REQ-006 Port: in_zero  input  1  upstream saw no request; entry carries no dispatch.
REQ-007 Port: in_ready  output  1  block can accept; equals !fifo_full (combinational).
REQ-008 Port: out_onehot  output  4  registered decoded grant, bit in_idx set.
REQ-009 Port: out_valid  output  1  registered; out_onehot is a live grant.
REQ-010 Port: out_ack  input  1  downstream completes current grant.
REQ-011 Port: err_pulse  output  1  registered one-cycle pulse on timeout completion.
REQ-012 Port: drop_cnt  output  8  registered saturating count of timeout completions.

Function
REQ-013 Transfer SHALL occur in a cycle with in_valid=1 and in_ready=1; else in_idx/in_zero are ignored.
REQ-014 Transferred entries with in_zero=0 SHALL be written to a 2-entry FIFO; entries with in_zero=1 SHALL be consumed without writing.
REQ-015 in_ready SHALL be 0 when the FIFO holds 2 entries, even if a pop occurs in the same cycle (no push-on-full).
REQ-016 FSM states SHALL be IDLE and DRIVE only.
REQ-017 IDLE with FIFO non-empty: pop head, load out_onehot = 1<<idx, out_valid=1, go DRIVE at the next edge.
REQ-018 Latency: entry transferred in cycle N into an empty FIFO while IDLE SHALL produce out_valid=1 in cycle N+2.
REQ-019 DRIVE: out_onehot and out_valid SHALL hold stable until completion (ack or timeout).
REQ-020 Completion with FIFO non-empty SHALL pop and drive the next grant in the following cycle, staying in DRIVE (back-to-back, no bubble).
REQ-021 Completion with FIFO empty SHALL return to IDLE with out_valid=0, out_onehot=4'b0000 in the following cycle.
REQ-022 out_ack SHALL be ignored while out_valid=0.
REQ-023 Simultaneous push and pop on a 1-entry FIFO SHALL leave occupancy 1 with correct ordering (FIFO order preserved).
REQ-024 Timeout counter (8-bit) SHALL clear on every grant load and increment each DRIVE cycle with out_ack=0.
REQ-025 Counter == TIMEOUT_CYC-1 with out_ack=0 SHALL be a timeout completion: err_pulse=1 next cycle, drop_cnt+1 saturating at 255.
REQ-026 out_ack=1 in the timeout cycle SHALL count as normal ack: no err_pulse, no drop_cnt increment.
REQ-027 out_onehot SHALL be 4'b0000 whenever out_valid=0, and exactly one-hot whenever out_valid=1.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE, FIFO empty, out_onehot=0, out_valid=0, err_pulse=0, drop_cnt=0, timeout counter=0.
REQ-029 in_ready SHALL be 1 during and after reset (FIFO empty).
REQ-030 Reset mid-grant SHALL discard the in-flight grant and all buffered entries; no err_pulse generated.

Configuration
REQ-031 Macro PRI_DEC_TIMEOUT_EN defined: REQ-024..026 timeout logic, err_pulse and drop_cnt behave as specified.
REQ-032 Macro PRI_DEC_TIMEOUT_EN undefined: no timeout counter; DRIVE waits indefinitely for out_ack; err_pulse and drop_cnt tied to 0; TIMEOUT_CYC unused.

Verification
REQ-033 Reset release, single transfer in_idx=2,in_zero=0 at cycle N -> out_onehot=4'b0100, out_valid=1 at N+2; ack -> out_valid=0, onehot=0 next cycle.
REQ-034 Three back-to-back transfers idx 3,1,0 with out_ack held 0 -> in_ready=0 after two buffered plus one driving; acks deliver 1000, 0010, 0001 in order with no idle cycle.
REQ-035 Transfer in_zero=1, in_idx=0 -> in_ready stays 1, out_valid never asserts.
REQ-036 TIMEOUT_CYC=4, grant idx 1, no ack -> completion after 4 DRIVE cycles, err_pulse one cycle, drop_cnt=1; ack exactly on 4th cycle -> err_pulse=0, drop_cnt unchanged.
REQ-037 rst_n low mid-DRIVE with 2 entries buffered -> outputs zero asynchronously, in_ready=1, nothing dispatched after release.
REQ-038 With PRI_DEC_TIMEOUT_EN undefined, grant held 300 cycles without ack -> out_valid stays 1, err_pulse=0, drop_cnt=0.

Source files
------------

// File: rtl/pri_decoder_dispatch.sv
// Priority-index dispatcher: 2-entry index FIFO feeding a one-hot grant that is held until ack.
// Define PRI_DEC_TIMEOUT_EN to enable forced completion after TIMEOUT_CYC unacknowledged cycles.
module pri_decoder_dispatch #(
  parameter int TIMEOUT_CYC = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [1:0] in_idx,
  input  logic       in_zero,
  output logic       in_ready,
  output logic [3:0] out_onehot,
  output logic       out_valid,
  input  logic       out_ack,
  output logic       err_pulse,
  output logic [7:0] drop_cnt
);

  typedef enum logic {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } state_t;

  state_t     state_reg, state_next;

  logic [1:0] fifo_mem_reg [2];
  logic       wr_ptr_reg, rd_ptr_reg;
  logic [1:0] count_reg, count_next;
  logic       fifo_nonempty;
  logic       push, pop, complete, tmo_fire;
  logic [1:0] head_idx;
  logic [3:0] head_onehot;

  logic [3:0] onehot_reg, onehot_next;
  logic       valid_reg, valid_next;

  // Full FIFO refuses input even if it pops this cycle, keeping in_ready off the pop path.
  assign in_ready      = (count_reg != 2'd2);
  assign fifo_nonempty = (count_reg != 2'd0);
  assign push          = in_valid && in_ready && !in_zero;
  assign head_idx      = fifo_mem_reg[rd_ptr_reg];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_dec
      assign head_onehot[gi] = (head_idx == 2'(gi));
    end
  endgenerate

  // out_ack only matters while a grant is live, which is exactly the DRIVE state.
  assign complete = (state_reg == DRIVE) && (out_ack || tmo_fire);
  assign pop      = fifo_nonempty && ((state_reg == IDLE) || complete);

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 2'd1;
      2'b01:   count_next = count_reg - 2'd1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem_reg[wr_ptr_reg] <= in_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (fifo_nonempty) state_next = DRIVE;
      DRIVE:   if (complete && !fifo_nonempty) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A pop always wins over a bare completion so back-to-back grants have no bubble.
  always_comb begin
    onehot_next = onehot_reg;
    valid_next  = valid_reg;
    if (pop) begin
      onehot_next = head_onehot;
      valid_next  = 1'b1;
    end else if (complete) begin
      onehot_next = 4'b0000;
      valid_next  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      onehot_reg <= 4'b0000;
      valid_reg  <= 1'b0;
    end else begin
      onehot_reg <= onehot_next;
      valid_reg  <= valid_next;
    end
  end

  assign out_onehot = onehot_reg;
  assign out_valid  = valid_reg;

`ifdef PRI_DEC_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

  logic [7:0] tmo_cnt_reg, tmo_cnt_next;
  logic       err_reg;
  logic [7:0] drop_reg, drop_next;

  // An ack in the final cycle takes precedence and counts as a normal completion.
  assign tmo_fire = (state_reg == DRIVE) && !out_ack && (tmo_cnt_reg == TMO_LAST);

  always_comb begin
    tmo_cnt_next = tmo_cnt_reg;
    if (pop || complete)
      tmo_cnt_next = 8'd0;
    else if ((state_reg == DRIVE) && !out_ack)
      tmo_cnt_next = tmo_cnt_reg + 8'd1;
  end

  always_comb begin
    drop_next = drop_reg;
    if (tmo_fire && (drop_reg != 8'hFF))
      drop_next = drop_reg + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_reg <= 8'd0;
      err_reg     <= 1'b0;
      drop_reg    <= 8'd0;
    end else begin
      tmo_cnt_reg <= tmo_cnt_next;
      err_reg     <= tmo_fire;
      drop_reg    <= drop_next;
    end
  end

  assign err_pulse = err_reg;
  assign drop_cnt  = drop_reg;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^(8'(TIMEOUT_CYC));
  assign tmo_fire  = 1'b0;
  assign err_pulse = 1'b0;
  assign drop_cnt  = 8'd0;
`endif

endmodule

// File: tb/tb_pri_decoder_dispatch.sv
// Directed self-checking bench for pri_decoder_dispatch; timeout steps follow PRI_DEC_TIMEOUT_EN.
module tb_pri_decoder_dispatch;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [1:0] in_idx;
  logic       in_zero;
  logic       in_ready;
  logic [3:0] out_onehot;
  logic       out_valid;
  logic       out_ack;
  logic       err_pulse;
  logic [7:0] drop_cnt;

  int n_vec;
  int n_err;

  pri_decoder_dispatch #(.TIMEOUT_CYC(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_idx     (in_idx),
    .in_zero    (in_zero),
    .in_ready   (in_ready),
    .out_onehot (out_onehot),
    .out_valid  (out_valid),
    .out_ack    (out_ack),
    .err_pulse  (err_pulse),
    .drop_cnt   (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int bad;
    n_vec    = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_idx   = 2'd0;
    in_zero  = 1'b0;
    out_ack  = 1'b0;

    // reset state
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_onehot", 32'(out_onehot), 32'h0);
    chk("rst_err", 32'(err_pulse), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    $display("txn reset released");

    // single transfer idx 2
    in_valid = 1'b1; in_idx = 2'd2; in_zero = 1'b0;
    step();
    in_valid = 1'b0;
    chk("single_n1_valid", 32'(out_valid), 32'd0);
    step();
    chk("single_n2_valid", 32'(out_valid), 32'd1);
    chk("single_n2_onehot", 32'(out_onehot), 32'h4);
    out_ack = 1'b1;
    step();
    out_ack = 1'b0;
    chk("single_ack_valid", 32'(out_valid), 32'd0);
    chk("single_ack_onehot", 32'(out_onehot), 32'h0);
    $display("txn single idx=2 onehot=0100 acked");

    // ack while idle is ignored
    out_ack = 1'b1;
    step();
    out_ack = 1'b0;
    chk("idle_ack_valid", 32'(out_valid), 32'd0);
    chk("idle_ack_drop", 32'(drop_cnt), 32'd0);

    // zero entry: consumed, never dispatched
    in_valid = 1'b1; in_idx = 2'd0; in_zero = 1'b1;
    step();
    in_valid = 1'b0; in_zero = 1'b0;
    chk("zero_in_ready", 32'(in_ready), 32'd1);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (out_valid !== 1'b0 || out_onehot !== 4'h0) bad++;
      step();
    end
    chk("zero_no_dispatch", 32'(bad), 32'd0);
    $display("txn zero entry consumed");

    // back-to-back 3,1,0 with ack held low
    in_valid = 1'b1; in_idx = 2'd3;
    step();
    chk("b2b_ready_a1", 32'(in_ready), 32'd1);
    in_idx = 2'd1;
    step();
    chk("b2b_ready_a2", 32'(in_ready), 32'd1);
    chk("b2b_first_onehot", 32'(out_onehot), 32'h8);
    in_idx = 2'd0;
    step();
    in_valid = 1'b0;
    chk("b2b_full_ready", 32'(in_ready), 32'd0);
    chk("b2b_hold_onehot", 32'(out_onehot), 32'h8);
    chk("b2b_hold_valid", 32'(out_valid), 32'd1);
    out_ack = 1'b1;
    step();
    chk("b2b_second_onehot", 32'(out_onehot), 32'h2);
    chk("b2b_second_valid", 32'(out_valid), 32'd1);
    chk("b2b_ready_after_pop", 32'(in_ready), 32'd1);
    step();
    chk("b2b_third_onehot", 32'(out_onehot), 32'h1);
    chk("b2b_third_valid", 32'(out_valid), 32'd1);
    step();
    out_ack = 1'b0;
    chk("b2b_done_valid", 32'(out_valid), 32'd0);
    chk("b2b_done_onehot", 32'(out_onehot), 32'h0);
    $display("txn back-to-back 1000,0010,0001 delivered");

`ifdef PRI_DEC_TIMEOUT_EN
    // timeout after 4 drive cycles
    in_valid = 1'b1; in_idx = 2'd1;
    step();
    in_valid = 1'b0;
    step();
    chk("tmo_d1_onehot", 32'(out_onehot), 32'h2);
    chk("tmo_d1_err", 32'(err_pulse), 32'd0);
    step();
    step();
    step();
    chk("tmo_d4_valid", 32'(out_valid), 32'd1);
    step();
    chk("tmo_done_valid", 32'(out_valid), 32'd0);
    chk("tmo_done_onehot", 32'(out_onehot), 32'h0);
    chk("tmo_err_pulse", 32'(err_pulse), 32'd1);
    chk("tmo_drop1", 32'(drop_cnt), 32'd1);
    step();
    chk("tmo_err_cleared", 32'(err_pulse), 32'd0);
    chk("tmo_drop_hold", 32'(drop_cnt), 32'd1);
    $display("txn timeout idx=1 drop_cnt=1");

    // ack on the 4th drive cycle is a normal completion
    in_valid = 1'b1; in_idx = 2'd2;
    step();
    in_valid = 1'b0;
    step();
    step();
    step();
    step();
    chk("tmoack_d4_valid", 32'(out_valid), 32'd1);
    out_ack = 1'b1;
    step();
    out_ack = 1'b0;
    chk("tmoack_valid", 32'(out_valid), 32'd0);
    chk("tmoack_err", 32'(err_pulse), 32'd0);
    chk("tmoack_drop", 32'(drop_cnt), 32'd1);
    $display("txn ack on final cycle, no drop");
`else
    // no timeout: grant held indefinitely
    in_valid = 1'b1; in_idx = 2'd1;
    step();
    in_valid = 1'b0;
    step();
    chk("hold_onehot", 32'(out_onehot), 32'h2);
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      if (out_valid !== 1'b1 || err_pulse !== 1'b0 || drop_cnt !== 8'd0) bad++;
      step();
    end
    chk("hold_300_cycles", 32'(bad), 32'd0);
    out_ack = 1'b1;
    step();
    out_ack = 1'b0;
    chk("hold_release_valid", 32'(out_valid), 32'd0);
    $display("txn grant held 300 cycles, released by ack");
`endif

    // async reset mid-drive with two buffered entries
    in_valid = 1'b1; in_idx = 2'd3;
    step();
    in_idx = 2'd1;
    step();
    in_idx = 2'd2;
    step();
    in_valid = 1'b0;
    chk("rstmid_full", 32'(in_ready), 32'd0);
    chk("rstmid_valid_before", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_valid", 32'(out_valid), 32'd0);
    chk("rstmid_onehot", 32'(out_onehot), 32'h0);
    chk("rstmid_ready", 32'(in_ready), 32'd1);
    chk("rstmid_err", 32'(err_pulse), 32'd0);
    chk("rstmid_drop", 32'(drop_cnt), 32'd0);
    step();
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (out_valid !== 1'b0 || out_onehot !== 4'h0 || err_pulse !== 1'b0) bad++;
    end
    chk("rstmid_no_dispatch", 32'(bad), 32'd0);
    chk("rstmid_ready_after", 32'(in_ready), 32'd1);
    $display("txn reset mid-drive discarded grant and buffer");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
